// File: rtl/sm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_pkg
// Description : Shared definitions for the surveillance-module ingress path.
//               Covers the DII flit type, header/payload geometry, the
//               debug-event flag encoding and the event filter state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package sm_pkg;

  // Packet geometry: 3 header flits (dest, src, flags) then 3 payload flits
  localparam int DII_HDR_LEN = 3;
  localparam int PAYLOAD_LEN = 3;

  // Flags flit layout for a debug-event write
  localparam int FLAG_TYPE_MSB    = 15;
  localparam int FLAG_TYPE_LSB    = 14;
  localparam int FLAG_SUBTYPE_MSB = 13;
  localparam int FLAG_SUBTYPE_LSB = 10;

  localparam logic [1:0] EVT_TYPE    = 2'b10;
  localparam logic [3:0] EVT_SUBTYPE = 4'h0;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef enum logic [3:0] {
    ST_DEST  = 4'd0,
    ST_SRC   = 4'd1,
    ST_FLAGS = 4'd2,
    ST_PAY0  = 4'd3,
    ST_PAY1  = 4'd4,
    ST_PAY2  = 4'd5,
    ST_DROP  = 4'd6,
    ST_EMIT0 = 4'd7,
    ST_EMIT1 = 4'd8,
    ST_EMIT2 = 4'd9
  } sm_event_filter_state_t;

  // True when the flags flit marks a debug-event register write
  function automatic logic is_write_event(input logic [15:0] flags);
    return (flags[FLAG_TYPE_MSB:FLAG_TYPE_LSB] == EVT_TYPE) &&
           (flags[FLAG_SUBTYPE_MSB:FLAG_SUBTYPE_LSB] == EVT_SUBTYPE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sm_sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset (count -> 0)
//               inc  - count one event this cycle
//               cnt  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sm_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != C_MAX)) begin
      cnt <= cnt + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm_event_filter.sv
`default_nettype none
// ============================================================================
// Module      : sm_event_filter
// Description : Ingress filter for the surveillance-module config path.
//               Keeps only debug-event writes addressed to MOD_ID, strips
//               the 3-flit header, checks the payload is exactly 3 flits and
//               replays it as a 3-cycle burst (addr, lo, hi+last).
//               Optional macro SM_EVENT_FILTER_SRC_CHECK_EN restricts the
//               accepted source address to ALLOWED_SRC.
// Ports       : clk          - clock
//               rst          - asynchronous active-high reset
//               dii_in       - packet stream from the debug ring
//               dii_in_ready - input flit consumed when valid && ready
//               dii_out      - cleaned write burst (no backpressure)
//               accepted_cnt - saturating count of forwarded writes
//               dropped_cnt  - saturating count of discarded packets
// Revision    : 1.0 - initial release
// ============================================================================
module sm_event_filter
  import sm_pkg::*;
#(
  parameter logic [15:0] MOD_ID      = 16'h0000,
  parameter logic [15:0] ALLOWED_SRC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  dii_flit     dii_in,
  output logic        dii_in_ready,
  output dii_flit     dii_out,
  output logic [15:0] accepted_cnt,
  output logic [15:0] dropped_cnt
);

  sm_event_filter_state_t state, state_nxt;

  logic [15:0] buf_addr;
  logic [15:0] buf_lo;
  logic [15:0] buf_hi;
  logic        consume;
  logic        drop_inc;
  logic        acc_inc;
  logic        src_mismatch;

  assign consume = dii_in.valid && dii_in_ready;

`ifdef SM_EVENT_FILTER_SRC_CHECK_EN
  // Captured while the source flit is consumed, consulted one flit later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_mismatch <= 1'b0;
    end else if (consume && (state == ST_SRC)) begin
      src_mismatch <= (dii_in.data != ALLOWED_SRC);
    end
  end
`else
  logic unused_allowed_src;
  assign src_mismatch       = 1'b0;
  assign unused_allowed_src = ^ALLOWED_SRC;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_DEST;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; a packet is counted as dropped on its last flit
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    drop_inc  = 1'b0;
    case (state)
      ST_DEST: begin
        if (consume) begin
          if (dii_in.last) begin
            drop_inc = 1'b1;
          end else if (dii_in.data == MOD_ID) begin
            state_nxt = ST_SRC;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_SRC: begin
        if (consume) begin
          if (dii_in.last) begin
            drop_inc  = 1'b1;
            state_nxt = ST_DEST;
          end else begin
            state_nxt = ST_FLAGS;
          end
        end
      end
      ST_FLAGS: begin
        if (consume) begin
          if (dii_in.last) begin
            drop_inc  = 1'b1;
            state_nxt = ST_DEST;
          end else if (is_write_event(dii_in.data) && !src_mismatch) begin
            state_nxt = ST_PAY0;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_PAY0, ST_PAY1: begin
        if (consume) begin
          if (dii_in.last) begin
            drop_inc  = 1'b1;
            state_nxt = ST_DEST;
          end else begin
            state_nxt = (state == ST_PAY0) ? ST_PAY1 : ST_PAY2;
          end
        end
      end
      ST_PAY2: begin
        if (consume) begin
          state_nxt = dii_in.last ? ST_EMIT0 : ST_DROP;
        end
      end
      ST_DROP: begin
        if (consume && dii_in.last) begin
          drop_inc  = 1'b1;
          state_nxt = ST_DEST;
        end
      end
      ST_EMIT0: state_nxt = ST_EMIT1;
      ST_EMIT1: state_nxt = ST_EMIT2;
      ST_EMIT2: state_nxt = ST_DEST;
      default:  state_nxt = ST_DEST;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from the registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    dii_in_ready = 1'b1;
    dii_out      = '0;
    acc_inc      = 1'b0;
    case (state)
      ST_EMIT0: begin
        dii_in_ready = 1'b0;
        dii_out      = '{valid: 1'b1, last: 1'b0, data: buf_addr};
      end
      ST_EMIT1: begin
        dii_in_ready = 1'b0;
        dii_out      = '{valid: 1'b1, last: 1'b0, data: buf_lo};
      end
      ST_EMIT2: begin
        dii_in_ready = 1'b0;
        dii_out      = '{valid: 1'b1, last: 1'b1, data: buf_hi};
        acc_inc      = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Payload capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_addr <= '0;
      buf_lo   <= '0;
      buf_hi   <= '0;
    end else if (consume) begin
      if (state == ST_PAY0) buf_addr <= dii_in.data;
      if (state == ST_PAY1) buf_lo   <= dii_in.data;
      if (state == ST_PAY2) buf_hi   <= dii_in.data;
    end
  end

  sm_sat_counter #(.WIDTH(16)) u_accepted_cnt (
    .clk (clk),
    .rst (rst),
    .inc (acc_inc),
    .cnt (accepted_cnt)
  );

  sm_sat_counter #(.WIDTH(16)) u_dropped_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop_inc),
    .cnt (dropped_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_sm_event_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_event_filter
// Description : Directed self-checking bench for sm_event_filter
//               (MOD_ID = 5, ALLOWED_SRC = 1). Honours the
//               SM_EVENT_FILTER_SRC_CHECK_EN macro when choosing expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_event_filter;
  import sm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  dii_flit     dii_in = '0;
  logic        dii_in_ready;
  dii_flit     dii_out;
  logic [15:0] accepted_cnt;
  logic [15:0] dropped_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [16:0] out_q[$];      // {last, data} of every valid output flit
  int          ready_low_cnt = 0;
  logic [15:0] pkt[8];

  sm_event_filter #(
    .MOD_ID      (16'h0005),
    .ALLOWED_SRC (16'h0001)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dii_in       (dii_in),
    .dii_in_ready (dii_in_ready),
    .dii_out      (dii_out),
    .accepted_cnt (accepted_cnt),
    .dropped_cnt  (dropped_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dii_out.valid) out_q.push_back({dii_out.last, dii_out.data});
    if (!dii_in_ready) ready_low_cnt++;
  end

  // Offer one flit; returns at the negedge after the edge that consumed it
  task automatic drive_flit(input logic [15:0] d, input logic l);
    int waited = 0;
    dii_in = '{valid: 1'b1, last: l, data: d};
    while (!dii_in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!dii_in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ready_timeout: ready=%b required 1", dii_in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_pkt(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        dii_in.valid = 1'b0;
        @(negedge clk);
      end
      drive_flit(pkt[i], i == n - 1);
    end
    dii_in = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    tests_run++;
    if (dii_in_ready !== 1'b1 || dii_out !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b out=%h required ready=1 out=0", dii_in_ready, dii_out);
    end
    tests_run++;
    if (accepted_cnt !== 16'h0 || dropped_cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_counters: acc=%h drop=%h required 0/0", accepted_cnt, dropped_cnt);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_valid_write;
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0300, 16'h1234, 16'hABCD, 16'h0, 16'h0};
    for (int i = 0; i < 5; i++) drive_flit(pkt[i], 1'b0);
    drive_flit(pkt[5], 1'b1);
    dii_in = '0;
    // Now one cycle after the edge that consumed the high word
    tests_run++;
    if (dii_out !== {1'b1, 1'b0, 16'h0300} || dii_in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_addr: out=%h ready=%b required %h ready=0", dii_out, dii_in_ready, {1'b1, 1'b0, 16'h0300});
    end
    @(negedge clk);
    tests_run++;
    if (dii_out !== {1'b1, 1'b0, 16'h1234}) begin
      tests_failed++;
      $display("FAIL write_lo: out=%h required %h", dii_out, {1'b1, 1'b0, 16'h1234});
    end
    @(negedge clk);
    tests_run++;
    if (dii_out !== {1'b1, 1'b1, 16'hABCD}) begin
      tests_failed++;
      $display("FAIL write_hi: out=%h required %h", dii_out, {1'b1, 1'b1, 16'hABCD});
    end
    @(negedge clk);
    tests_run++;
    if (dii_out.valid !== 1'b0 || dii_in_ready !== 1'b1 || accepted_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL write_done: valid=%b ready=%b acc=%0d required 0/1/1", dii_out.valid, dii_in_ready, accepted_cnt);
    end
  endtask

  task automatic test_wrong_dest;
    out_q.delete();
    pkt = '{16'h0006, 16'h0001, 16'h8000, 16'h0300, 16'h1234, 16'hABCD, 16'h0, 16'h0};
    send_pkt(6, 0);
    idle(4);
    tests_run++;
    if (out_q.size() != 0 || dropped_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL wrong_dest: out_flits=%0d drop=%0d required 0/1", out_q.size(), dropped_cnt);
    end
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0010, 16'h5555, 16'hAAAA, 16'h0, 16'h0};
    send_pkt(6, 0);
    idle(5);
    tests_run++;
    if (out_q.size() != 3 || out_q[0] !== {1'b0, 16'h0010} || out_q[1] !== {1'b0, 16'h5555} ||
        out_q[2] !== {1'b1, 16'hAAAA} || accepted_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL after_drop_write: flits=%0d acc=%0d required 3 flits 0010/5555/AAAA acc=2", out_q.size(), accepted_cnt);
    end
  endtask

  task automatic test_bad_length;
    out_q.delete();
    // last on PAY1
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0300, 16'h1234, 16'h0, 16'h0, 16'h0};
    send_pkt(5, 0);
    // 7-flit packet overruns PAY2
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0301, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    send_pkt(7, 0);
    idle(4);
    tests_run++;
    if (out_q.size() != 0 || dropped_cnt !== 16'd3 || accepted_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL short_long: flits=%0d drop=%0d acc=%0d required 0/3/2", out_q.size(), dropped_cnt, accepted_cnt);
    end
    // Single-flit packet: last while still on the destination flit
    pkt[0] = 16'h0005;
    send_pkt(1, 0);
    idle(2);
    tests_run++;
    if (dropped_cnt !== 16'd4) begin
      tests_failed++;
      $display("FAIL one_flit: drop=%0d required 4", dropped_cnt);
    end
    // Wrong event type in the flags flit
    pkt = '{16'h0005, 16'h0001, 16'h4000, 16'h0302, 16'h1111, 16'h2222, 16'h0, 16'h0};
    send_pkt(6, 0);
    idle(4);
    tests_run++;
    if (out_q.size() != 0 || dropped_cnt !== 16'd5) begin
      tests_failed++;
      $display("FAIL bad_flags: flits=%0d drop=%0d required 0/5", out_q.size(), dropped_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [16:0] exp[6];
    exp = '{{1'b0, 16'h0020}, {1'b0, 16'h1111}, {1'b1, 16'h2222},
            {1'b0, 16'h0021}, {1'b0, 16'h3333}, {1'b1, 16'h4444}};
    out_q.delete();
    ready_low_cnt = 0;
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0020, 16'h1111, 16'h2222, 16'h0, 16'h0};
    send_pkt(6, 2);
    // Next packet is offered straight away, so valid is high across EMIT
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0021, 16'h3333, 16'h4444, 16'h0, 16'h0};
    send_pkt(6, 0);
    idle(6);
    tests_run++;
    if (ready_low_cnt != 6) begin
      tests_failed++;
      $display("FAIL ready_low_cycles: %0d required 6", ready_low_cnt);
    end
    tests_run++;
    if (out_q.size() != 6) begin
      tests_failed++;
      $display("FAIL b2b_count: flits=%0d required 6", out_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (out_q[i] !== exp[i]) begin
          tests_failed++;
          $display("FAIL b2b_flit%0d: got %h required %h", i, out_q[i], exp[i]);
        end
      end
    end
    tests_run++;
    if (accepted_cnt !== 16'd4 || dropped_cnt !== 16'd5) begin
      tests_failed++;
      $display("FAIL b2b_counters: acc=%0d drop=%0d required 4/5", accepted_cnt, dropped_cnt);
    end
  endtask

  task automatic test_src_check;
    out_q.delete();
    pkt = '{16'h0005, 16'h0002, 16'h8000, 16'h0040, 16'h0A0A, 16'h0B0B, 16'h0, 16'h0};
    send_pkt(6, 0);
    idle(5);
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0041, 16'h0C0C, 16'h0D0D, 16'h0, 16'h0};
    send_pkt(6, 0);
    idle(5);
`ifdef SM_EVENT_FILTER_SRC_CHECK_EN
    tests_run++;
    if (out_q.size() != 3 || out_q[0] !== {1'b0, 16'h0041} || out_q[2] !== {1'b1, 16'h0D0D} ||
        accepted_cnt !== 16'd5 || dropped_cnt !== 16'd6) begin
      tests_failed++;
      $display("FAIL src_check_on: flits=%0d acc=%0d drop=%0d required 3/5/6", out_q.size(), accepted_cnt, dropped_cnt);
    end
`else
    tests_run++;
    if (out_q.size() != 6 || out_q[0] !== {1'b0, 16'h0040} || out_q[3] !== {1'b0, 16'h0041} ||
        accepted_cnt !== 16'd6 || dropped_cnt !== 16'd5) begin
      tests_failed++;
      $display("FAIL src_check_off: flits=%0d acc=%0d drop=%0d required 6/6/5", out_q.size(), accepted_cnt, dropped_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_burst;
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0050, 16'h1357, 16'h2468, 16'h0, 16'h0};
    send_pkt(6, 0);
    @(negedge clk);  // now in EMIT1
    tests_run++;
    if (dii_out !== {1'b1, 1'b0, 16'h1357}) begin
      tests_failed++;
      $display("FAIL emit1_before_rst: out=%h required %h", dii_out, {1'b1, 1'b0, 16'h1357});
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (dii_out.valid !== 1'b0 || dii_in_ready !== 1'b1 || accepted_cnt !== 16'd0 || dropped_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b ready=%b acc=%0d drop=%0d required 0/1/0/0",
               dii_out.valid, dii_in_ready, accepted_cnt, dropped_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    out_q.delete();
    pkt = '{16'h0005, 16'h0001, 16'h8000, 16'h0051, 16'h0001, 16'h0002, 16'h0, 16'h0};
    send_pkt(6, 0);
    idle(5);
    tests_run++;
    if (out_q.size() != 3 || out_q[0] !== {1'b0, 16'h0051} || accepted_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL post_reset_write: flits=%0d acc=%0d required 3/1", out_q.size(), accepted_cnt);
    end
  endtask

  task automatic test_saturation;
    force dut.u_dropped_cnt.cnt = 16'hFFFE;
    #1;
    release dut.u_dropped_cnt.cnt;
    @(negedge clk);
    tests_run++;
    if (dropped_cnt !== 16'hFFFE) begin
      tests_failed++;
      $display("FAIL preload: drop=%h required FFFE", dropped_cnt);
    end
    pkt[0] = 16'h0007;
    send_pkt(1, 0);
    idle(1);
    tests_run++;
    if (dropped_cnt !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL reach_max: drop=%h required FFFF", dropped_cnt);
    end
    send_pkt(1, 0);
    idle(1);
    tests_run++;
    if (dropped_cnt !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL saturate: drop=%h required FFFF", dropped_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_write();
    test_wrong_dest();
    test_bad_length();
    test_back_to_back();
    test_src_check();
    test_reset_mid_burst();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
